// File: rtl/neighbor_selector.sv
// neighbor_selector: scans the neighbor table over its read port and selects
// the best next hop (highest Q, then fewest hops, then lowest index).
// Optional build macro: ENERGY_FILTER_EN adds an energyThreshold input and
// skips entries whose energy is below it.
module neighbor_selector #(
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 32,
    localparam int AW = $clog2(MAX_NEIGHBORS),
    localparam int CW = $clog2(MAX_NEIGHBORS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  HB_Reset,
    input  logic [CW-1:0]         numNeighbors,
`ifdef ENERGY_FILTER_EN
    input  logic [WORD_WIDTH-1:0] energyThreshold,
`endif
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [WORD_WIDTH-1:0] mNodeID,
    input  logic [WORD_WIDTH-1:0] mNodeHops,
    input  logic [WORD_WIDTH-1:0] mNodeQValue,
    input  logic [WORD_WIDTH-1:0] mNodeEnergy,
    input  logic [WORD_WIDTH-1:0] mNodeCHHops,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [WORD_WIDTH-1:0] bestID,
    output logic [WORD_WIDTH-1:0] bestQValue,
    output logic [WORD_WIDTH-1:0] bestHops,
    output logic [WORD_WIDTH-1:0] bestCHHops,
    output logic [AW-1:0]         bestIndex
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [WORD_WIDTH-1:0] HOPS_NONE = {WORD_WIDTH{1'b1}};
    localparam logic [CW-1:0]         N_MAX     = CW'(MAX_NEIGHBORS);

    state_t                state_q, state_d;
    logic [CW-1:0]         n_q, n_d;
    logic                  rd_en_q, rd_en_d;
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    // Read data returns one cycle after the strobe; these track that slot.
    logic                  vld_q, vld_d;
    logic [AW-1:0]         vld_idx_q, vld_idx_d;
    logic                  cand_vld_q, cand_vld_d;
    logic [WORD_WIDTH-1:0] cand_id_q, cand_id_d;
    logic [WORD_WIDTH-1:0] cand_qv_q, cand_qv_d;
    logic [WORD_WIDTH-1:0] cand_hops_q, cand_hops_d;
    logic [WORD_WIDTH-1:0] cand_ch_q, cand_ch_d;
    logic [AW-1:0]         cand_idx_q, cand_idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  found_q, found_d;
    logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
    logic [WORD_WIDTH-1:0] best_qv_q, best_qv_d;
    logic [WORD_WIDTH-1:0] best_hops_q, best_hops_d;
    logic [WORD_WIDTH-1:0] best_ch_q, best_ch_d;
    logic [AW-1:0]         best_idx_q, best_idx_d;

    logic                  qualify;
    logic                  take;
    logic                  last_addr;
    logic [CW-1:0]         n_clamped;

    // Decide whether the entry returning this cycle displaces the candidate.
    always_comb begin
`ifdef ENERGY_FILTER_EN
        qualify = (mNodeEnergy >= energyThreshold);
`else
        qualify = 1'b1;
`endif
        take = vld_q && qualify &&
               (!cand_vld_q ||
                (mNodeQValue > cand_qv_q) ||
                ((mNodeQValue == cand_qv_q) && (mNodeHops < cand_hops_q)));
        last_addr = ({{(CW-AW){1'b0}}, rd_addr_q} == (n_q - CW'(1)));
        n_clamped = (numNeighbors > N_MAX) ? N_MAX : numNeighbors;
    end

    // Next-state logic: scan sequencing, candidate tracking and result latch.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        vld_d       = rd_en_q;
        vld_idx_d   = rd_addr_q;
        cand_vld_d  = cand_vld_q;
        cand_id_d   = cand_id_q;
        cand_qv_d   = cand_qv_q;
        cand_hops_d = cand_hops_q;
        cand_ch_d   = cand_ch_q;
        cand_idx_d  = cand_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        found_d     = found_q;
        best_id_d   = best_id_q;
        best_qv_d   = best_qv_q;
        best_hops_d = best_hops_q;
        best_ch_d   = best_ch_q;
        best_idx_d  = best_idx_q;

        if (take) begin
            cand_vld_d  = 1'b1;
            cand_id_d   = mNodeID;
            cand_qv_d   = mNodeQValue;
            cand_hops_d = mNodeHops;
            cand_ch_d   = mNodeCHHops;
            cand_idx_d  = vld_idx_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d         = n_clamped;
                    busy_d      = 1'b1;
                    cand_vld_d  = 1'b0;
                    cand_id_d   = '0;
                    cand_qv_d   = '0;
                    cand_hops_d = HOPS_NONE;
                    cand_ch_d   = HOPS_NONE;
                    cand_idx_d  = '0;
                    if (n_clamped == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d   = S_ISSUE;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (last_addr) begin
                    rd_en_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                // The last entry's compare result is folded straight into the
                // outputs so they are valid in the same cycle as done.
                state_d     = S_DONE;
                done_d      = 1'b1;
                found_d     = cand_vld_d;
                best_id_d   = cand_id_d;
                best_qv_d   = cand_qv_d;
                best_hops_d = cand_hops_d;
                best_ch_d   = cand_ch_d;
                best_idx_d  = cand_idx_d;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Heartbeat reset wins over everything, including a same-cycle start.
        if (HB_Reset) begin
            state_d     = S_IDLE;
            rd_en_d     = 1'b0;
            vld_d       = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            cand_vld_d  = 1'b0;
            found_d     = 1'b0;
            best_id_d   = '0;
            best_qv_d   = '0;
            best_hops_d = HOPS_NONE;
            best_ch_d   = HOPS_NONE;
            best_idx_d  = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            vld_q       <= 1'b0;
            vld_idx_q   <= '0;
            cand_vld_q  <= 1'b0;
            cand_id_q   <= '0;
            cand_qv_q   <= '0;
            cand_hops_q <= HOPS_NONE;
            cand_ch_q   <= HOPS_NONE;
            cand_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            best_id_q   <= '0;
            best_qv_q   <= '0;
            best_hops_q <= HOPS_NONE;
            best_ch_q   <= HOPS_NONE;
            best_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            vld_q       <= vld_d;
            vld_idx_q   <= vld_idx_d;
            cand_vld_q  <= cand_vld_d;
            cand_id_q   <= cand_id_d;
            cand_qv_q   <= cand_qv_d;
            cand_hops_q <= cand_hops_d;
            cand_ch_q   <= cand_ch_d;
            cand_idx_q  <= cand_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            best_id_q   <= best_id_d;
            best_qv_q   <= best_qv_d;
            best_hops_q <= best_hops_d;
            best_ch_q   <= best_ch_d;
            best_idx_q  <= best_idx_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign found      = found_q;
    assign bestID     = best_id_q;
    assign bestQValue = best_qv_q;
    assign bestHops   = best_hops_q;
    assign bestCHHops = best_ch_q;
    assign bestIndex  = best_idx_q;

endmodule
